// File: rtl/bsg_link_sdr_reset_sequencer.sv
// bsg_link_sdr_reset_sequencer
//   Generates the ordered bring-up sequence for a pair of bsg_link_sdr
//   channels and the attached node core: an async token reset pulse, then
//   uplink, downlink, downstream and core resets released one at a time
//   with programmable settle gaps. restart_i aborts and returns to IDLE.
//
// Ports:
//   clk_i                    sequencer clock
//   reset_n_i                asynchronous active-low reset
//   start_i                  begin sequence (sampled only in IDLE)
//   restart_i                abort and return to IDLE, all resets asserted
//   async_token_reset_o      active-high token reset pulse
//   async_uplink_reset_o     uplink reset, 1 = in reset
//   async_downlink_reset_o   downlink reset, 1 = in reset
//   async_downstream_reset_o downstream reset, 1 = in reset
//   core_reset_o             node / core reset, 1 = in reset
//   done_o                   sequence complete, all resets released
//   state_o                  current state encoding (debug)
module bsg_link_sdr_reset_sequencer #(
  parameter int token_cycles_p = 16,
  parameter int step_cycles_p  = 64,
  parameter bit auto_start_p   = 1'b0
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       start_i,
  input  logic       restart_i,
  output logic       async_token_reset_o,
  output logic       async_uplink_reset_o,
  output logic       async_downlink_reset_o,
  output logic       async_downstream_reset_o,
  output logic       core_reset_o,
  output logic       done_o,
  output logic [2:0] state_o
);

  localparam int max_cycles_lp = (token_cycles_p > step_cycles_p) ? token_cycles_p : step_cycles_p;
  localparam int cnt_width_lp  = ((max_cycles_lp + 1) <= 1) ? 1 : $clog2(max_cycles_lp + 1);

  if (token_cycles_p < 1) begin : g_token_check
    $error("token_cycles_p must be >= 1");
  end
  if (step_cycles_p < 1) begin : g_step_check
    $error("step_cycles_p must be >= 1");
  end

  typedef logic [cnt_width_lp-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TOKEN  = 3'd1,
    SETTLE = 3'd2,
    UP     = 3'd3,
    DOWN   = 3'd4,
    DSTRM  = 3'd5,
    DONE   = 3'd6
  } state_e;

  localparam cnt_t token_load = cnt_t'(token_cycles_p - 1);
  localparam cnt_t step_load  = cnt_t'(step_cycles_p - 1);

  state_e state, state_next;
  cnt_t   cnt, cnt_next;

  logic tok, up, down, dstrm, core, done;
  logic tok_next, up_next, down_next, dstrm_next, core_next, done_next;

  // State register. Each output is decoded from the *next* state and
  // captured in its own flop, so outputs change on the same edge as state
  // yet never carry combinational decode glitches into other domains.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      cnt   <= '0;
      tok   <= 1'b0;
      up    <= 1'b1;
      down  <= 1'b1;
      dstrm <= 1'b1;
      core  <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      tok   <= tok_next;
      up    <= up_next;
      down  <= down_next;
      dstrm <= dstrm_next;
      core  <= core_next;
      done  <= done_next;
    end
  end

  // Next-state and phase counter.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (restart_i) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i || auto_start_p) begin
            state_next = TOKEN;
            cnt_next   = token_load;
          end
        end
        TOKEN, SETTLE, UP, DOWN: begin
          if (cnt == '0) begin
            state_next = state_e'(state + 3'd1);
            cnt_next   = step_load;
          end else begin
            cnt_next = cnt - cnt_t'(1);
          end
        end
        DSTRM: begin
          if (cnt == '0) begin
            state_next = DONE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt - cnt_t'(1);
          end
        end
        DONE: begin
          state_next = DONE;
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Output decode of the next state, feeding the output flops.
  always_comb begin
    tok_next   = 1'b0;
    up_next    = 1'b1;
    down_next  = 1'b1;
    dstrm_next = 1'b1;
    core_next  = 1'b1;
    done_next  = 1'b0;
    unique case (state_next)
      IDLE, SETTLE: ;
      TOKEN: tok_next = 1'b1;
      UP: up_next = 1'b0;
      DOWN: begin
        up_next   = 1'b0;
        down_next = 1'b0;
      end
      DSTRM: begin
        up_next    = 1'b0;
        down_next  = 1'b0;
        dstrm_next = 1'b0;
      end
      DONE: begin
        up_next    = 1'b0;
        down_next  = 1'b0;
        dstrm_next = 1'b0;
        core_next  = 1'b0;
        done_next  = 1'b1;
      end
      default: ;
    endcase
  end

  assign async_token_reset_o      = tok;
  assign async_uplink_reset_o     = up;
  assign async_downlink_reset_o   = down;
  assign async_downstream_reset_o = dstrm;
  assign core_reset_o             = core;
  assign done_o                   = done;
  assign state_o                  = state;

endmodule

// File: tb/tb_bsg_link_sdr_reset_sequencer.sv
// Testbench for bsg_link_sdr_reset_sequencer.
// Three instances: A (T=2,S=4), B (T=16,S=4), C (T=1,S=1,auto start).
// Observed vector = {tok, up, down, dstrm, core, done, state[2:0]}.
module tb_bsg_link_sdr_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [8:0] RST_VEC = 9'b0_1111_0_000;

  // Instance A
  logic a_rst_n, a_start, a_restart;
  logic a_tok, a_up, a_down, a_dstrm, a_core, a_done;
  logic [2:0] a_state;
  logic [8:0] a_obs;
  assign a_obs = {a_tok, a_up, a_down, a_dstrm, a_core, a_done, a_state};

  // Instance B
  logic b_rst_n, b_start, b_restart;
  logic b_tok, b_up, b_down, b_dstrm, b_core, b_done;
  logic [2:0] b_state;
  logic [8:0] b_obs;
  assign b_obs = {b_tok, b_up, b_down, b_dstrm, b_core, b_done, b_state};

  // Instance C
  logic c_rst_n, c_start, c_restart;
  logic c_tok, c_up, c_down, c_dstrm, c_core, c_done;
  logic [2:0] c_state;
  logic [8:0] c_obs;
  assign c_obs = {c_tok, c_up, c_down, c_dstrm, c_core, c_done, c_state};

  bsg_link_sdr_reset_sequencer #(.token_cycles_p(2), .step_cycles_p(4), .auto_start_p(1'b0)) dut_a (
    .clk_i(clk), .reset_n_i(a_rst_n), .start_i(a_start), .restart_i(a_restart),
    .async_token_reset_o(a_tok), .async_uplink_reset_o(a_up),
    .async_downlink_reset_o(a_down), .async_downstream_reset_o(a_dstrm),
    .core_reset_o(a_core), .done_o(a_done), .state_o(a_state)
  );

  bsg_link_sdr_reset_sequencer #(.token_cycles_p(16), .step_cycles_p(4), .auto_start_p(1'b0)) dut_b (
    .clk_i(clk), .reset_n_i(b_rst_n), .start_i(b_start), .restart_i(b_restart),
    .async_token_reset_o(b_tok), .async_uplink_reset_o(b_up),
    .async_downlink_reset_o(b_down), .async_downstream_reset_o(b_dstrm),
    .core_reset_o(b_core), .done_o(b_done), .state_o(b_state)
  );

  bsg_link_sdr_reset_sequencer #(.token_cycles_p(1), .step_cycles_p(1), .auto_start_p(1'b1)) dut_c (
    .clk_i(clk), .reset_n_i(c_rst_n), .start_i(c_start), .restart_i(c_restart),
    .async_token_reset_o(c_tok), .async_uplink_reset_o(c_up),
    .async_downlink_reset_o(c_down), .async_downstream_reset_o(c_dstrm),
    .core_reset_o(c_core), .done_o(c_done), .state_o(c_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected state after edge e when start was driven in cycle 0 (sampled at edge 1).
  function automatic int exp_state(int e, int t, int s);
    if (e < 1)                 return 0;
    else if (e < 1 + t)        return 1;
    else if (e < 1 + t + s)    return 2;
    else if (e < 1 + t + 2*s)  return 3;
    else if (e < 1 + t + 3*s)  return 4;
    else if (e < 1 + t + 4*s)  return 5;
    else                       return 6;
  endfunction

  // Hand-written output table per state: {tok,up,down,dstrm,core,done,state}.
  function automatic logic [8:0] exp_vec(int st);
    case (st)
      0:       return 9'b0_1111_0_000;
      1:       return 9'b1_1111_0_001;
      2:       return 9'b0_1111_0_010;
      3:       return 9'b0_0111_0_011;
      4:       return 9'b0_0011_0_100;
      5:       return 9'b0_0001_0_101;
      default: return 9'b0_0000_1_110;
    endcase
  endfunction

  task automatic test_reset();
    a_rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a_start   = i[0];
      a_restart = i[1];
      tick();
      compared++;
      if (a_obs !== RST_VEC) begin
        mismatched++;
        $display("FAIL reset_hold i=%0d got=%b want=%b", i, a_obs, RST_VEC);
      end
    end
    a_start = 1'b0;
    a_restart = 1'b0;
    a_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if (a_obs !== RST_VEC) begin
        mismatched++;
        $display("FAIL reset_release_idle i=%0d got=%b want=%b", i, a_obs, RST_VEC);
      end
    end
  endtask

  // Nominal T=2,S=4: up falls 7, down 11, dstrm 15, done 19.
  // A stray start in cycle 9 (UP) must be ignored; DONE must hold.
  task automatic test_nominal();
    logic [8:0] exp;
    compared++;
    if (a_obs !== exp_vec(0)) begin
      mismatched++;
      $display("FAIL nominal_pre got=%b want=%b", a_obs, exp_vec(0));
    end
    a_start = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      tick();
      a_start = (e == 9);
      exp = exp_vec(exp_state(e, 2, 4));
      compared++;
      if (a_obs !== exp) begin
        mismatched++;
        $display("FAIL nominal e=%0d got=%b want=%b", e, a_obs, exp);
      end
    end
    a_start = 1'b0;
  endtask

  task automatic test_restart_mid_phase();
    logic [8:0] exp;
    a_restart = 1'b1;
    tick();
    a_restart = 1'b0;
    compared++;
    if (a_obs !== RST_VEC) begin
      mismatched++;
      $display("FAIL restart_from_done got=%b want=%b", a_obs, RST_VEC);
    end
    a_start = 1'b1;
    for (int e = 1; e <= 36; e++) begin
      tick();
      a_start   = (e == 14);
      a_restart = (e == 12);
      if (e < 13)      exp = exp_vec(exp_state(e, 2, 4));
      else if (e < 15) exp = RST_VEC;
      else             exp = exp_vec(exp_state(e - 14, 2, 4));
      compared++;
      if (a_obs !== exp) begin
        mismatched++;
        $display("FAIL restart_mid e=%0d got=%b want=%b", e, a_obs, exp);
      end
    end
    // Held restart keeps IDLE even with start asserted; no start afterwards stays IDLE.
    a_restart = 1'b1;
    for (int i = 0; i < 7; i++) begin
      a_start = i[0];
      if (i == 4) a_restart = 1'b0;
      if (i >= 4) a_start = 1'b0;
      tick();
      compared++;
      if (a_obs !== RST_VEC) begin
        mismatched++;
        $display("FAIL restart_hold i=%0d got=%b want=%b", i, a_obs, RST_VEC);
      end
    end
  endtask

  task automatic test_collision();
    a_restart = 1'b1;
    a_start   = 1'b1;
    tick();
    compared++;
    if (a_obs !== RST_VEC) begin
      mismatched++;
      $display("FAIL collision_idle got=%b want=%b", a_obs, RST_VEC);
    end
    a_restart = 1'b0;
    tick();
    a_start = 1'b0;
    compared++;
    if (a_obs !== exp_vec(1)) begin
      mismatched++;
      $display("FAIL collision_start got=%b want=%b", a_obs, exp_vec(1));
    end
    tick();
    compared++;
    if (a_obs !== exp_vec(1)) begin
      mismatched++;
      $display("FAIL collision_token2 got=%b want=%b", a_obs, exp_vec(1));
    end
    tick();
    compared++;
    if (a_obs !== exp_vec(2)) begin
      mismatched++;
      $display("FAIL collision_settle got=%b want=%b", a_obs, exp_vec(2));
    end
    a_restart = 1'b1;
    tick();
    a_restart = 1'b0;
  endtask

  task automatic test_async_reset();
    b_rst_n = 1'b1;
    tick();
    compared++;
    if (b_obs !== RST_VEC) begin
      mismatched++;
      $display("FAIL async_pre got=%b want=%b", b_obs, RST_VEC);
    end
    b_start = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      b_start = 1'b0;
      compared++;
      if (b_obs !== exp_vec(1)) begin
        mismatched++;
        $display("FAIL async_token e=%0d got=%b want=%b", e, b_obs, exp_vec(1));
      end
    end
    // Mid-cycle: no clock edge between the drop and the check.
    #2 b_rst_n = 1'b0;
    #1;
    compared++;
    if (b_obs !== RST_VEC) begin
      mismatched++;
      $display("FAIL async_cut got=%b want=%b", b_obs, RST_VEC);
    end
    tick();
    b_rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      compared++;
      if (b_obs !== RST_VEC) begin
        mismatched++;
        $display("FAIL async_stay_idle i=%0d got=%b want=%b", i, b_obs, RST_VEC);
      end
    end
  endtask

  task automatic test_auto_start();
    logic [8:0] exp;
    compared++;
    if (c_obs !== RST_VEC) begin
      mismatched++;
      $display("FAIL auto_in_reset got=%b want=%b", c_obs, RST_VEC);
    end
    c_rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp = exp_vec(exp_state(e, 1, 1));
      compared++;
      if (c_obs !== exp) begin
        mismatched++;
        $display("FAIL auto_seq e=%0d got=%b want=%b", e, c_obs, exp);
      end
    end
    c_restart = 1'b1;
    tick();
    c_restart = 1'b0;
    compared++;
    if (c_obs !== RST_VEC) begin
      mismatched++;
      $display("FAIL auto_restart got=%b want=%b", c_obs, RST_VEC);
    end
    tick();
    compared++;
    if (c_obs !== exp_vec(1)) begin
      mismatched++;
      $display("FAIL auto_resume got=%b want=%b", c_obs, exp_vec(1));
    end
    tick();
    compared++;
    if (c_obs !== exp_vec(2)) begin
      mismatched++;
      $display("FAIL auto_resume_settle got=%b want=%b", c_obs, exp_vec(2));
    end
  endtask

  initial begin
    a_rst_n = 1'b0; a_start = 1'b0; a_restart = 1'b0;
    b_rst_n = 1'b0; b_start = 1'b0; b_restart = 1'b0;
    c_rst_n = 1'b0; c_start = 1'b0; c_restart = 1'b0;
    tick();
    tick();
    test_reset();
    test_nominal();
    test_restart_mid_phase();
    test_collision();
    test_async_reset();
    test_auto_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bsg_link_sdr_reset_sequencer.md
Name: bsg_link_sdr_reset_sequencer

Overview:
- Single-clock controller that generates the ordered bring-up sequence for a pair of bsg_link_sdr channels (fwd and rev) and the manycore node core reset.
- Drives the async token reset pulse, then releases uplink, downlink, downstream and core resets one at a time, with programmable settle gaps.
- Sits next to the SDR corner / gateway logic and replaces hand-timed reset stimulus. Also supports a restart, which re-enters reset after a link fault.

Parameters:
- token_cycles_p, 16: clk_i cycles that async_token_reset_o is held high; must be >= 1.
- step_cycles_p, 64: clk_i cycles spent in each settle/release phase; must be >= 1.
- auto_start_p, 0: 1 = leave IDLE without start_i once reset_n_i deasserts; 0 = wait for start_i.
- cnt_width_lp, derived: `BSG_SAFE_CLOG2(max(token_cycles_p, step_cycles_p)+1), phase counter width.

Ports:
- clk_i  in  1  sequencer clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  begin sequence; sampled only in IDLE.
- restart_i  in  1  abort any phase and return to IDLE with all resets asserted.
- async_token_reset_o  out  1  to bsg_link_sdr async_token_reset_i; active-high pulse.
- async_uplink_reset_o  out  1  to uplink reset (both links); 1 = in reset.
- async_downlink_reset_o  out  1  to async_downlink_reset_i; 1 = in reset.
- async_downstream_reset_o  out  1  to downstream reset; 1 = in reset.
- core_reset_o  out  1  node / core reset; 1 = in reset.
- done_o  out  1  sequence complete, all resets released.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- Clock and reset: one clock, clk_i. reset_n_i is asynchronous and active-low. All flops clear when reset_n_i is low, and release is synchronous to clk_i.
- Reset values: state=IDLE, counter=0, async_token_reset_o=0, all other reset outputs=1, done_o=0.
- Glitch-free outputs: every reset output comes directly from a dedicated flop, never from combinational state decode. These outputs cross into other clock domains.
- States and encoding: IDLE=0, TOKEN=1, SETTLE=2, UP=3, DOWN=4, DSTRM=5, DONE=6.
- Output values per state (outputs are registered and change on the same edge as state):
  - IDLE: tok=0, up=1, down=1, dstrm=1, core=1, done=0.
  - TOKEN: tok=1, everything else as in IDLE.
  - SETTLE: tok=0.
  - UP: up=0.
  - DOWN: up=0, down=0.
  - DSTRM: up=0, down=0, dstrm=0.
  - DONE: all reset outputs 0, done_o=1.
- Transitions:
  - IDLE -> TOKEN when start_i (or auto_start_p) is sampled 1; the counter loads token_cycles_p-1.
  - TOKEN -> SETTLE -> UP -> DOWN -> DSTRM -> DONE, each advancing when counter==0. Each load uses step_cycles_p-1.
  - The counter decrements every cycle otherwise; it never wraps.
  - DONE is terminal until restart_i.
- Phase lengths: TOKEN lasts exactly token_cycles_p cycles. SETTLE, UP, DOWN and DSTRM each last exactly step_cycles_p cycles.
- Latency: with start_i sampled at edge 0, the outputs change at these edges:
  - async_token_reset_o rises at edge 1.
  - async_uplink_reset_o falls at 1+T+S.
  - async_downlink_reset_o falls at 1+T+2S.
  - async_downstream_reset_o falls at 1+T+3S.
  - core_reset_o falls and done_o rises at 1+T+4S.
- restart_i, any state: on the next edge state=IDLE and outputs take their reset values. It overrides start_i in the same cycle; the sequence does not begin until start_i is seen in IDLE after restart_i drops. While restart_i is held, the block stays in IDLE. With auto_start_p=1, the sequence restarts on the first cycle restart_i is 0.
- start_i outside IDLE is ignored, with no effect on the counter.
- reset_n_i asserted mid-sequence: the block returns immediately, asynchronously, to reset values. A token pulse in progress is cut short.
- Assertions: token_cycles_p>=1 and step_cycles_p>=1 are checked at elaboration.

Test Plan:
- Nominal sequence, T=2, S=4, start_i pulsed at edge 0:
  - token high during cycles 1-2.
  - up falls at 7, down falls at 11, dstrm falls at 15, core falls and done rises at 19.
  - state_o steps through 0,1,2,3,4,5,6.
- Reset values: hold reset_n_i=0, toggle start_i and restart_i -> tok=0, up/down/dstrm/core=1, done=0, state_o=0 throughout.
- Restart mid-phase: with T=2, S=4, assert restart_i at cycle 12 (DOWN) -> at edge 13 up/down/dstrm/core=1, state_o=0. start_i at 14 -> token high cycles 15-16 and done at 33.
- Restart/start collision: restart_i=1 and start_i=1 in IDLE on the same cycle -> remains IDLE. A following start_i alone starts the sequence, with token high one cycle later.
- Async reset mid-token: with T=16, drop reset_n_i at cycle 5 between edges -> token output falls without waiting for a clock edge. After release, with auto_start_p=0 and start_i=0, the block stays in IDLE for 100 cycles.
- Auto-start, T=1, S=1: with auto_start_p=1, release reset_n_i at edge 0 -> token high cycle 1 only. up falls at 3, down at 4, dstrm at 5, done at 6.
- Integration: connect to two bsg_link_sdr instances and a test node pair -> after done_o, 1000 packets are sent and received with no error.
